regfile_wr_arb: RTL

REGFILE_WR_ARB -- requirements
Module: regfile_wr_arb

---
 rtl/regfile_wr_arb.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/regfile_wr_arb.sv
// -----------------------------------------------------------------------------
// regfile_wr_arb
//
// Arbitrates two writers onto the single write port of an 8 x 16-bit register
// file. Requester A is the CPU writeback path and requester B is the
// debug/switch loader. A round-robin pointer resolves contention. Every output
// is registered, so a request sampled at one rising edge appears on the write
// port during the following cycle.
//
// Optional feature, selected by the macro REGFILE_CLEAR_EN:
//   defined   - after every reset an 8-cycle CLEAR sequence writes 16'h0000 to
//               registers 0..7, and BUSY is high while it runs.
//   undefined - there is no CLEAR state or index counter, BUSY is tied low, and
//               arbitration starts the cycle after reset.
//
// Ports
//   Clk     in   1   clock; all state changes on the rising edge
//   Reset   in   1   synchronous, active-high reset
//   REQ_A   in   1   requester A wants a write; held until GNT_A is seen
//   DR_A    in   3   requester A destination register
//   DATA_A  in  16   requester A write data
//   GNT_A   out  1   one-cycle pulse: A's write is on the port this cycle
//   REQ_B   in   1   requester B wants a write; held until GNT_B is seen
//   DR_B    in   3   requester B destination register
//   DATA_B  in  16   requester B write data
//   GNT_B   out  1   one-cycle pulse: B's write is on the port this cycle
//   LD_REG  out  1   register-file write enable
//   DR      out  3   register-file destination index
//   BUS     out 16   register-file write data
//   BUSY    out  1   high while the clear sequence runs
// -----------------------------------------------------------------------------
module regfile_wr_arb (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        REQ_A,
  input  logic [2:0]  DR_A,
  input  logic [15:0] DATA_A,
  output logic        GNT_A,
  input  logic        REQ_B,
  input  logic [2:0]  DR_B,
  input  logic [15:0] DATA_B,
  output logic        GNT_B,
  output logic        LD_REG,
  output logic [2:0]  DR,
  output logic [15:0] BUS,
  output logic        BUSY
);

  typedef enum logic {PRIO_A = 1'b0, PRIO_B = 1'b1} prio_t;

  prio_t       prio, prio_nxt;
  logic        elig_a, elig_b;
  logic        pick_a, pick_b;
  logic        arb_en;
  logic        ld_nxt, gnt_a_nxt, gnt_b_nxt;
  logic [2:0]  dr_nxt;
  logic [15:0] bus_nxt;

`ifdef REGFILE_CLEAR_EN
  typedef enum logic {CLEAR = 1'b0, ARB = 1'b1} state_t;

  state_t     state, state_nxt;
  logic [2:0] idx, idx_nxt;
  logic       busy_nxt;
`else
  assign BUSY = 1'b0;
`endif

  // A requester that is being granted this cycle is still presenting the same
  // request at the closing edge; masking it out prevents a second write of the
  // same data. This also limits a lone requester to one write every two cycles.
  assign elig_a = REQ_A & ~GNT_A;
  assign elig_b = REQ_B & ~GNT_B;

  // A lone eligible requester wins outright; the pointer only breaks ties.
  assign pick_a = elig_a & (~elig_b | (prio == PRIO_A));
  assign pick_b = elig_b & ~pick_a;

  // NOTE: every signal written here gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    ld_nxt    = 1'b0;
    gnt_a_nxt = 1'b0;
    gnt_b_nxt = 1'b0;
    dr_nxt    = DR;
    bus_nxt   = BUS;
    prio_nxt  = prio;
    arb_en    = 1'b1;

`ifdef REGFILE_CLEAR_EN
    state_nxt = state;
    idx_nxt   = idx;
    busy_nxt  = 1'b0;
    arb_en    = 1'b0;
    case (state)
      CLEAR: begin
        // BUSY is registered alongside the write it accompanies, so it stays
        // high through the write of register 7 and drops with the first
        // arbitrated cycle.
        ld_nxt   = 1'b1;
        dr_nxt   = idx;
        bus_nxt  = 16'h0000;
        busy_nxt = 1'b1;
        idx_nxt  = idx + 3'd1;
        if (idx == 3'd7) begin
          state_nxt = ARB;
        end
      end
      ARB: begin
        arb_en = 1'b1;
      end
    endcase
`endif

    if (arb_en) begin
      if (pick_a) begin
        ld_nxt    = 1'b1;
        gnt_a_nxt = 1'b1;
        dr_nxt    = DR_A;
        bus_nxt   = DATA_A;
        prio_nxt  = PRIO_B;
      end else if (pick_b) begin
        ld_nxt    = 1'b1;
        gnt_b_nxt = 1'b1;
        dr_nxt    = DR_B;
        bus_nxt   = DATA_B;
        prio_nxt  = PRIO_A;
      end
    end
  end

  // NOTE: state and output registers use non-blocking assignments so every
  // register samples the pre-edge values computed above.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      LD_REG <= 1'b0;
      DR     <= 3'b000;
      BUS    <= 16'h0000;
      GNT_A  <= 1'b0;
      GNT_B  <= 1'b0;
      prio   <= PRIO_A;
`ifdef REGFILE_CLEAR_EN
      state  <= CLEAR;
      idx    <= 3'd0;
      BUSY   <= 1'b1;
`endif
    end else begin
      LD_REG <= ld_nxt;
      DR     <= dr_nxt;
      BUS    <= bus_nxt;
      GNT_A  <= gnt_a_nxt;
      GNT_B  <= gnt_b_nxt;
      prio   <= prio_nxt;
`ifdef REGFILE_CLEAR_EN
      state  <= state_nxt;
      idx    <= idx_nxt;
      BUSY   <= busy_nxt;
`endif
    end
  end

endmodule
